// File: rtl/key_pkg.sv
// Shared definitions for the push-button timer: FSM encoding, default timing
// parameters and the hold-time display mapping.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } key_state_t;

  localparam int CLK_HZ_DEF   = 12_000_000;
  localparam int DEB_CYC_DEF  = 240_000;
  localparam int LONG_SEC_DEF = 2;

  localparam logic [2:0] HOLD_MAX = 3'd7;

  function automatic logic [3:0] thermo(input logic [2:0] h);
    logic [3:0] t;
    for (int i = 0; i < 4; i++) begin
      t[i] = (int'(h) > i);
    end
    return t;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input; the reset value
// is a parameter so idle-high and idle-low inputs both start in their idle state.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_press_timer.sv
// Debounced push-button timer: measures how many whole seconds a key is held and
// classifies each accepted release as a short or a long press.
module key_press_timer
  import key_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_DEF,
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int LONG_SEC = LONG_SEC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output logic       pressed,
  output logic       press_short,
  output logic       press_long,
  output logic [2:0] hold_sec,
  output logic [3:0] led
);

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int SEC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);

  key_state_t       state;
  logic             key_s;
  logic             armed;
  logic [1:0]       settle;
  logic [DEB_W-1:0] deb_cnt;
  logic [SEC_W-1:0] sec_cnt;
  logic             sec_wrap;
  logic [2:0]       hold_next;
  logic             rel_long;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == HOLD_MAX) ? v : v + 3'd1;
  endfunction

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_n),
    .q     (key_s)
  );

  // Classification must see a second boundary landing in the release cycle.
  always_comb begin
    sec_wrap  = (sec_cnt == SEC_LAST);
    hold_next = sec_wrap ? sat_inc(hold_sec) : hold_sec;
    rel_long  = (int'(hold_next) >= LONG_SEC);
  end

  assign led = thermo(hold_sec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      sec_cnt     <= '0;
      hold_sec    <= '0;
      pressed     <= 1'b0;
      press_short <= 1'b0;
      press_long  <= 1'b0;
      armed       <= 1'b0;
      settle      <= 2'd0;
    end else begin
      press_short <= 1'b0;
      press_long  <= 1'b0;

      // A key still held through reset must be released before it can count:
      // arm only once the synchronizer has flushed and shows the key up.
      if (settle != 2'd2) begin
        settle <= settle + 2'd1;
      end else if (key_s) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (armed && !key_s) begin
            state   <= DEB_PRESS;
            deb_cnt <= '0;
          end
        end

        DEB_PRESS: begin
          if (key_s) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= HELD;
            pressed  <= 1'b1;
            hold_sec <= '0;
            sec_cnt  <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        HELD, DEB_REL: begin
          sec_cnt  <= sec_wrap ? '0 : sec_cnt + SEC_W'(1);
          hold_sec <= hold_next;
          if (state == HELD) begin
            if (key_s) begin
              state   <= DEB_REL;
              deb_cnt <= '0;
            end
          end else if (!key_s) begin
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= IDLE;
            pressed     <= 1'b0;
            press_long  <= rel_long;
            press_short <= !rel_long;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_timer.sv
// Scoreboard bench for key_press_timer with short timing parameters.
module tb_key_press_timer;

  localparam int CLK_HZ   = 100;
  localparam int DEB_CYC  = 10;
  localparam int LONG_SEC = 2;
  // key_n rising at negedge n0+m (n0 = first negedge showing pressed) is
  // accepted at posedge m + 3 + DEB_CYC after the press was accepted.
  localparam int REL_LAT  = 3 + DEB_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       pressed;
  logic       press_short;
  logic       press_long;
  logic [2:0] hold_sec;
  logic [3:0] led;

  typedef struct {
    logic [1:0] kind;   // {long, short}
    logic [2:0] hold;
    logic [3:0] led;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  key_press_timer #(
    .CLK_HZ   (CLK_HZ),
    .DEB_CYC  (DEB_CYC),
    .LONG_SEC (LONG_SEC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .pressed     (pressed),
    .press_short (press_short),
    .press_long  (press_long),
    .hold_sec    (hold_sec),
    .led         (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] led_ref(input int h);
    if (h >= 4) return 4'hf;
    return 4'((1 << h) - 1);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (press_short || press_long)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, press_long, press_short}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {30'd0, press_long, press_short}, {30'd0, e.kind});
        check("pulse_hold", {29'd0, hold_sec}, {29'd0, e.hold});
        check("pulse_led", {28'd0, led}, {28'd0, e.led});
        check("pulse_pressed_low", {31'd0, pressed}, 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sb(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check({tag, "_pulse_seen"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic press(input string tag);
    key_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pressed) break;
    end
    check({tag, "_pressed"}, {31'd0, pressed}, 32'd1);
    check({tag, "_hold_clear"}, {29'd0, hold_sec}, 32'd0);
    check({tag, "_led_clear"}, {28'd0, led}, 32'd0);
  endtask

  task automatic release_now(input int m, input string tag);
    exp_t e;
    int   h;
    key_n = 1'b1;
    h = (m + REL_LAT) / CLK_HZ;
    if (h > 7) h = 7;
    e.kind = (h >= LONG_SEC) ? 2'b10 : 2'b01;
    e.hold = 3'(h);
    e.led  = led_ref(h);
    sb.push_back(e);
    wait_sb(tag);
  endtask

  task automatic release_after(input int m, input string tag);
    cyc(m);
    release_now(m, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;

    cyc(3);
    check("rst_pressed", {31'd0, pressed}, 32'd0);
    check("rst_short", {31'd0, press_short}, 32'd0);
    check("rst_long", {31'd0, press_long}, 32'd0);
    check("rst_hold", {29'd0, hold_sec}, 32'd0);
    check("rst_led", {28'd0, led}, 32'd0);
    rst_n = 1'b1;
    cyc(10);

    // Bounce: 5 low, 3 high, then stable low; accept 2 sync + DEB_CYC later
    key_n = 1'b0;
    ok = 1'b0;
    repeat (5) begin @(negedge clk); ok |= pressed; end
    key_n = 1'b1;
    repeat (3) begin @(negedge clk); ok |= pressed; end
    key_n = 1'b0;
    repeat (12) begin @(negedge clk); ok |= pressed; end
    check("bounce_early", {31'd0, ok}, 32'd0);
    @(negedge clk);
    check("bounce_rise", {31'd0, pressed}, 32'd1);
    check("bounce_hold0", {29'd0, hold_sec}, 32'd0);
    release_after(150, "short");
    cyc(20);
    check("retain_hold", {29'd0, hold_sec}, 32'd1);
    check("retain_led", {28'd0, led}, 32'b0001);
    cyc(20);

    // Long press saturating at 7
    press("long");
    release_after(900, "long");
    cyc(20);
    check("retain_hold7", {29'd0, hold_sec}, 32'd7);
    check("retain_led7", {28'd0, led}, 32'hf);
    cyc(20);

    // Release accepted on the cycle hold_sec wraps to 2, and one cycle earlier
    press("edge_long");
    release_after(200 - REL_LAT, "edge_long");
    cyc(20);
    press("edge_short");
    release_after(199 - REL_LAT, "edge_short");
    cyc(20);

    // Release glitch while held
    press("glitch");
    cyc(80);
    key_n = 1'b1;
    cyc(4);
    key_n = 1'b0;
    ok = 1'b1;
    repeat (15) begin @(negedge clk); ok &= pressed; end
    check("glitch_pressed", {31'd0, ok}, 32'd1);
    check("glitch_hold_pre", {29'd0, hold_sec}, 32'd0);
    cyc(1);
    check("glitch_hold_cont", {29'd0, hold_sec}, 32'd1);
    cyc(20);
    release_now(120, "glitch");
    cyc(20);

    // Reset in the middle of a press
    press("rst_mid");
    cyc(300);
    check("rst_mid_hold3", {29'd0, hold_sec}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_pressed", {31'd0, pressed}, 32'd0);
    check("rst_mid_hold", {29'd0, hold_sec}, 32'd0);
    check("rst_mid_led", {28'd0, led}, 32'd0);
    check("rst_mid_pulses", {30'd0, press_long, press_short}, 32'd0);
    cyc(3);
    rst_n = 1'b1;
    ok = 1'b0;
    repeat (40) begin @(negedge clk); ok |= pressed; end
    check("rst_held_ignored", {31'd0, ok}, 32'd0);
    key_n = 1'b1;
    cyc(40);
    check("rst_release_quiet", {31'd0, pressed}, 32'd0);
    press("fresh");
    release_after(150, "fresh");
    cyc(20);

    check("sb_final_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
